tcdm_bank_adapter: RTL and testbench
====================================

TCDM_BANK_ADAPTER -- requirements
Module: tcdm_bank_adapter

Interface
REQ-001 SHALL have parameter NumBanks, default 4 (BankingFactor): number of word-interleaved SRAM banks served.
REQ-002 SHALL have parameter BankAddrWidth, default 12 (TCDMAddrMemWidth): row address width per bank.
REQ-003 SHALL have parameter RespDepth, default 2: response buffer entries (>=1).
REQ-004 SHALL have clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have tile_req_i, input, tile_req_t: tile request (req, addr, we, wdata, be).
REQ-007 SHALL have tile_resp_o, output, tile_resp_t: gnt, vld, rdata.
REQ-008 SHALL have resp_ready_i, input, 1: consumer accepts the response when vld && resp_ready_i.
REQ-009 SHALL have bank_req_o, output, NumBanks: one-hot bank select.
REQ-010 SHALL have bank_we_o, bank_addr_o [BankAddrWidth], bank_wdata_o [32], bank_be_o [4], all outputs, shared by all banks.
REQ-011 SHALL have bank_rdata_i, input, NumBanks x 32: bank read data, valid exactly one cycle after bank_req_o.

Function
REQ-012 Address split: addr[1:0] byte offset (ignored); bank = addr[3:2]; row = addr[2+log2(NumBanks)+BankAddrWidth-1 : 2+log2(NumBanks)], i.e. row = addr[15:4] for defaults.
REQ-013 Out-of-range: addr[31:16] != 0 (defaults) SHALL be granted without asserting any bank_req_o; a read SHALL return rdata 32'hBADCAB1E; a write SHALL be dropped.
REQ-014 gnt SHALL be combinational: gnt = req && (count + inflight < RespDepth); count = buffered responses, inflight = reads granted in the previous cycle (0 or 1).
REQ-015 On gnt, the bank selected by REQ-012 SHALL see bank_req_o=1 with we, row, wdata, be in that same cycle; no bank access without gnt.
REQ-016 Only reads generate responses; granted writes produce no vld.
REQ-017 Read latency SHALL be 1 cycle: a read granted in cycle t makes its response available in cycle t+1.
REQ-018 Bypass: if the buffer is empty in cycle t+1, vld=1 and rdata=bank_rdata_i[bank of t] combinationally; if resp_ready_i=0 that data SHALL be written into the buffer at end of t+1.
REQ-019 If the buffer is non-empty, vld=1 and rdata = head entry; arriving read data SHALL be appended at tail; order SHALL always equal grant order.
REQ-020 Simultaneous pop (vld && resp_ready_i) and arrival SHALL update count by net 0; buffer SHALL never overflow by construction of REQ-014.
REQ-021 Bank index and out-of-range flag of an in-flight read SHALL be registered in cycle t and used to select data in t+1.
REQ-022 Back-to-back reads SHALL sustain one grant per cycle while resp_ready_i=1.
REQ-023 tile_resp_o.vld SHALL be 0 whenever count=0 and inflight=0.

Reset
REQ-024 While rst_i=1: count=0, inflight=0, buffer pointers=0, gnt=0, vld=0, rdata=0, bank_req_o=0.
REQ-025 Reset asserted mid-operation SHALL discard buffered and in-flight responses; first grant possible in the first cycle after rst_i deasserts.

Verification
REQ-026 Read addr 0x0000_0014, resp_ready_i=1 -> cycle t: gnt=1, bank_req_o=4'b0010, bank_addr_o=1; t+1: vld=1, rdata=bank_rdata_i[1].
REQ-027 Write addr 0x0000_000C, wdata 0xDEADBEEF, be 4'hF -> gnt=1, bank_req_o=4'b1000, bank_addr_o=0, bank_we_o=1; no vld afterwards.
REQ-028 Three back-to-back reads, resp_ready_i=0 -> gnt=1,1,0 (RespDepth=2); after resp_ready_i=1, responses return in order, then third read granted.
REQ-029 Read addr 0x0001_0000 -> gnt=1, bank_req_o=0, next cycle rdata=32'hBADCAB1E.
REQ-030 Buffer holding 1 response, pop and new arrival in same cycle -> count stays 1, order preserved.
REQ-031 rst_i pulsed for 1 cycle with 2 buffered responses -> vld=0 next cycle, count=0, no stale data ever delivered.

Source files
------------

// File: rtl/tcdm_bank_adapter.sv
// Adapts a single tile request port onto NumBanks word-interleaved SRAM banks.
// 1-cycle read latency with a small response FIFO plus bypass for backpressure.
package tcdm_bank_adapter_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } tile_req_t;

  typedef struct packed {
    logic        gnt;
    logic        vld;
    logic [31:0] rdata;
  } tile_resp_t;
endpackage

module tcdm_bank_adapter
  import tcdm_bank_adapter_pkg::*;
#(
  parameter int NumBanks      = 4,
  parameter int BankAddrWidth = 12,
  parameter int RespDepth     = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  tile_req_t                        tile_req_i,
  output tile_resp_t                       tile_resp_o,
  input  logic                             resp_ready_i,
  output logic [NumBanks-1:0]              bank_req_o,
  output logic                             bank_we_o,
  output logic [BankAddrWidth-1:0]         bank_addr_o,
  output logic [31:0]                      bank_wdata_o,
  output logic [3:0]                       bank_be_o,
  input  logic [NumBanks-1:0][31:0]        bank_rdata_i
);

  localparam int BankLog = (NumBanks > 1) ? $clog2(NumBanks) : 0;
  localparam int BankW   = (NumBanks > 1) ? BankLog : 1;
  localparam int RowLsb  = 2 + BankLog;
  localparam int OorLsb  = RowLsb + BankAddrWidth;
  localparam int PtrW    = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int CntW    = $clog2(RespDepth + 1);

  logic [BankW-1:0]                 bank_idx;
  logic [31:0]                      addr_hi;
  logic                             oor;
  logic                             gnt, vld, pop, pop_buf, push;
  logic [31:0]                      rdata, arr_data;

  logic [CntW-1:0]                  count_q;
  logic                             inflight_q;
  logic [BankW-1:0]                 inf_bank_q;
  logic                             inf_oor_q;
  logic [PtrW-1:0]                  rd_ptr_q, wr_ptr_q;
  logic [RespDepth-1:0][31:0]       rbuf_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (int'(p) == RespDepth - 1) ? '0 : p + 1'b1;
  endfunction

  generate
    if (NumBanks > 1) begin : g_bank_idx
      assign bank_idx = tile_req_i.addr[2 +: BankW];
    end else begin : g_one_bank
      assign bank_idx = '0;
    end
  endgenerate

  // Anything above the last row bit is outside the TCDM window.
  assign addr_hi = tile_req_i.addr >> OorLsb;
  assign oor     = |addr_hi;

  assign gnt = !rst_i && tile_req_i.req &&
               ((int'(count_q) + int'(inflight_q)) < RespDepth);

  always_comb begin
    bank_req_o = '0;
    if (gnt && !oor) bank_req_o[bank_idx] = 1'b1;
  end

  assign bank_we_o    = tile_req_i.we;
  assign bank_addr_o  = tile_req_i.addr[RowLsb +: BankAddrWidth];
  assign bank_wdata_o = tile_req_i.wdata;
  assign bank_be_o    = tile_req_i.be;

  assign arr_data = inf_oor_q ? 32'hBADC_AB1E : bank_rdata_i[inf_bank_q];

  // Head of the FIFO wins; with an empty FIFO the arriving bank data bypasses.
  assign vld   = !rst_i && ((count_q != '0) || inflight_q);
  assign rdata = !vld ? '0 : ((count_q != '0) ? rbuf_q[rd_ptr_q] : arr_data);

  assign pop     = vld && resp_ready_i;
  assign pop_buf = pop && (count_q != '0);
  assign push    = inflight_q && !((count_q == '0) && resp_ready_i);

  always_comb begin
    tile_resp_o       = '0;
    tile_resp_o.gnt   = gnt;
    tile_resp_o.vld   = vld;
    tile_resp_o.rdata = rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      inf_bank_q <= '0;
      inf_oor_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= gnt && !tile_req_i.we;
      inf_bank_q <= bank_idx;
      inf_oor_q  <= oor;
      if (push) begin
        rbuf_q[wr_ptr_q] <= arr_data;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop_buf) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(push) - CntW'(pop_buf);
    end
  end

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Directed bench for tcdm_bank_adapter with a 4-bank read model.
module tb_tcdm_bank_adapter;
  import tcdm_bank_adapter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  tile_req_t         treq;
  tile_resp_t        tresp;
  logic              ready;
  logic [3:0]        bank_req;
  logic              bank_we;
  logic [11:0]       bank_addr;
  logic [31:0]       bank_wdata;
  logic [3:0]        bank_be;
  logic [3:0][31:0]  bank_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tcdm_bank_adapter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tile_req_i   (treq),
    .tile_resp_o  (tresp),
    .resp_ready_i (ready),
    .bank_req_o   (bank_req),
    .bank_we_o    (bank_we),
    .bank_addr_o  (bank_addr),
    .bank_wdata_o (bank_wdata),
    .bank_be_o    (bank_be),
    .bank_rdata_i (bank_rdata)
  );

  // Read data pattern: 0xB0 | bank | 0 | row, one cycle after the request.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bank_req[b] && !bank_we)
        bank_rdata[b] <= {8'hB0, 8'(b), 4'h0, bank_addr};
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic r, input logic [31:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] b);
    treq.req = r; treq.addr = a; treq.we = w; treq.wdata = d; treq.be = b;
  endtask

  task automatic test_reset;
    rst = 1'b1; ready = 1'b1; drv(1'b1, 32'h14, 1'b0, 32'h0, 4'hF);
    tick; tick;
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%h exp=0", tresp.gnt); end
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%h exp=0", tresp.vld); end
    total++; if (tresp.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", tresp.rdata); end
    total++; if (bank_req !== 4'b0) begin bad++; $display("FAIL rst_bank_req got=%b exp=0000", bank_req); end
    tick; rst = 1'b0; drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    tick;
  endtask

  task automatic test_read;
    ready = 1'b1; drv(1'b1, 32'h0000_0014, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%h exp=1", tresp.gnt); end
    total++; if (bank_req !== 4'b0010) begin bad++; $display("FAIL rd_bank_req got=%b exp=0010", bank_req); end
    total++; if (bank_addr !== 12'd1) begin bad++; $display("FAIL rd_bank_addr got=%h exp=1", bank_addr); end
    total++; if (bank_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%h exp=0", bank_we); end
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL rd_vld_early got=%h exp=0", tresp.vld); end
    tick; drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (tresp.vld !== 1'b1) begin bad++; $display("FAIL rd_vld got=%h exp=1", tresp.vld); end
    total++; if (tresp.rdata !== 32'hB001_0001) begin bad++; $display("FAIL rd_rdata got=%h exp=b0010001", tresp.rdata); end
    tick;
    @(negedge clk);
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL rd_vld_after got=%h exp=0", tresp.vld); end
  endtask

  task automatic test_write;
    tick; ready = 1'b1; drv(1'b1, 32'h0000_000C, 1'b1, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%h exp=1", tresp.gnt); end
    total++; if (bank_req !== 4'b1000) begin bad++; $display("FAIL wr_bank_req got=%b exp=1000", bank_req); end
    total++; if (bank_addr !== 12'd0) begin bad++; $display("FAIL wr_bank_addr got=%h exp=0", bank_addr); end
    total++; if (bank_we !== 1'b1) begin bad++; $display("FAIL wr_we got=%h exp=1", bank_we); end
    total++; if (bank_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_wdata got=%h exp=deadbeef", bank_wdata); end
    total++; if (bank_be !== 4'hF) begin bad++; $display("FAIL wr_be got=%h exp=f", bank_be); end
    tick; drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL wr_no_vld got=%h exp=0", tresp.vld); end
  endtask

  task automatic test_oor;
    tick; ready = 1'b1; drv(1'b1, 32'h0001_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL oor_gnt got=%h exp=1", tresp.gnt); end
    total++; if (bank_req !== 4'b0) begin bad++; $display("FAIL oor_bank_req got=%b exp=0000", bank_req); end
    tick; drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (tresp.vld !== 1'b1) begin bad++; $display("FAIL oor_vld got=%h exp=1", tresp.vld); end
    total++; if (tresp.rdata !== 32'hBADC_AB1E) begin bad++; $display("FAIL oor_rdata got=%h exp=badcab1e", tresp.rdata); end
  endtask

  task automatic test_backpressure;
    tick; ready = 1'b0; drv(1'b1, 32'h04, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL bp_gnt0 got=%h exp=1", tresp.gnt); end
    tick; drv(1'b1, 32'h28, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL bp_gnt1 got=%h exp=1", tresp.gnt); end
    total++; if (tresp.rdata !== 32'hB001_0000) begin bad++; $display("FAIL bp_rdata1 got=%h exp=b0010000", tresp.rdata); end
    tick; drv(1'b1, 32'h3C, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b0) begin bad++; $display("FAIL bp_gnt2 got=%h exp=0", tresp.gnt); end
    total++; if (bank_req !== 4'b0) begin bad++; $display("FAIL bp_bank_req2 got=%b exp=0000", bank_req); end
    tick; ready = 1'b1;
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b0) begin bad++; $display("FAIL bp_gnt3 got=%h exp=0", tresp.gnt); end
    total++; if (tresp.rdata !== 32'hB001_0000) begin bad++; $display("FAIL bp_resp_a got=%h exp=b0010000", tresp.rdata); end
    tick;
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL bp_gnt4 got=%h exp=1", tresp.gnt); end
    total++; if (tresp.rdata !== 32'hB002_0002) begin bad++; $display("FAIL bp_resp_b got=%h exp=b0020002", tresp.rdata); end
    tick; drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (tresp.rdata !== 32'hB003_0003) begin bad++; $display("FAIL bp_resp_c got=%h exp=b0030003", tresp.rdata); end
    tick;
    @(negedge clk);
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL bp_drained got=%h exp=0", tresp.vld); end
  endtask

  task automatic test_pop_arrival;
    tick; ready = 1'b0; drv(1'b1, 32'h20, 1'b0, 32'h0, 4'hF);
    tick; drv(1'b1, 32'h54, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL pa_gnt got=%h exp=1", tresp.gnt); end
    tick; ready = 1'b1; drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (tresp.rdata !== 32'hB000_0002) begin bad++; $display("FAIL pa_head got=%h exp=b0000002", tresp.rdata); end
    tick;
    @(negedge clk);
    total++; if (tresp.vld !== 1'b1) begin bad++; $display("FAIL pa_vld got=%h exp=1", tresp.vld); end
    total++; if (tresp.rdata !== 32'hB001_0005) begin bad++; $display("FAIL pa_second got=%h exp=b0010005", tresp.rdata); end
    tick;
    @(negedge clk);
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL pa_count1 got=%h exp=0", tresp.vld); end
  endtask

  task automatic test_reset_mid;
    tick; ready = 1'b0; drv(1'b1, 32'h04, 1'b0, 32'h0, 4'hF);
    tick; drv(1'b1, 32'h28, 1'b0, 32'h0, 4'hF);
    tick; drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    tick; rst = 1'b1;
    @(negedge clk);
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL rm_vld_in_rst got=%h exp=0", tresp.vld); end
    tick; rst = 1'b0; drv(1'b1, 32'h30, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL rm_vld_after got=%h exp=0", tresp.vld); end
    total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL rm_first_gnt got=%h exp=1", tresp.gnt); end
    tick; ready = 1'b1; drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (tresp.rdata !== 32'hB000_0003) begin bad++; $display("FAIL rm_fresh got=%h exp=b0000003", tresp.rdata); end
    tick;
    @(negedge clk);
    total++; if (tresp.vld !== 1'b0) begin bad++; $display("FAIL rm_no_stale got=%h exp=0", tresp.vld); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    logic [31:0] exps  [4];
    addrs = '{32'h00, 32'h14, 32'h28, 32'h3C};
    exps  = '{32'hB000_0000, 32'hB001_0001, 32'hB002_0002, 32'hB003_0003};
    tick; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drv(1'b1, addrs[i], 1'b0, 32'h0, 4'hF);
      else       drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      if (i < 4) begin
        total++; if (tresp.gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt%0d got=%h exp=1", i, tresp.gnt); end
      end
      if (i > 0) begin
        total++; if (tresp.rdata !== exps[i-1]) begin bad++; $display("FAIL b2b_rdata%0d got=%h exp=%h", i, tresp.rdata, exps[i-1]); end
      end
      tick;
    end
  endtask

  initial begin
    drv(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    rst = 1'b1; ready = 1'b1; bank_rdata = '0;
    test_reset;
    test_read;
    test_write;
    test_oor;
    test_backpressure;
    test_pop_arrival;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
